// File: rtl/memctrl_arbiter_if.sv
// Requester handshake and MEMCTRL strobe bundle between memctrl_arbiter and its environment.
// Index 0/1 of each vector belongs to requester 0/1.
interface memctrl_arbiter_if;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       req_we;
    logic [1:0][15:0] req_addr;
    logic [1:0][7:0]  req_wdata;
    logic [1:0]       rsp_valid;
    logic [1:0][7:0]  rsp_rdata;
    logic [15:0]      m_addr;
    logic             m_ce;
    logic             m_csb;
    logic             m_web;
    logic             m_oeb;
    logic [7:0]       m_idata;
    logic [7:0]       m_odata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, m_odata,
        output req_ready, rsp_valid, rsp_rdata,
        output m_addr, m_ce, m_csb, m_web, m_oeb, m_idata
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, m_odata,
        input  req_ready, rsp_valid, rsp_rdata,
        input  m_addr, m_ce, m_csb, m_web, m_oeb, m_idata
    );
endinterface

// File: rtl/memctrl_arbiter.sv
// Two-port round-robin arbiter and strobe sequencer in front of MEMCTRL.
// One access is in flight at a time; its response returns to the granted requester.
module memctrl_arbiter #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    memctrl_arbiter_if.slave io_bus
);

    typedef enum logic [1:0] {StIdle, StStrobe, StWait, StRecov} state_e;

    localparam logic [2:0] LatCnt = 3'(RD_LAT);

    state_e          r_state;
    state_e          w_state_d;
    logic            r_pri;
    logic            r_id;
    logic            r_we;
    logic [2:0]      r_cnt;
    logic [2:0]      w_cnt_d;

    logic            w_accept;
    logic            w_winner;
    logic [1:0]      w_ready;

    logic [15:0]     r_m_addr;
    logic            r_m_ce;
    logic            r_m_csb;
    logic            r_m_web;
    logic            r_m_oeb;
    logic [7:0]      r_m_idata;
    logic [1:0]      r_rsp_valid;
    logic [1:0][7:0] r_rsp_rdata;

    logic [15:0]     w_m_addr_d;
    logic            w_m_ce_d;
    logic            w_m_csb_d;
    logic            w_m_web_d;
    logic            w_m_oeb_d;
    logic [7:0]      w_m_idata_d;
    logic [1:0]      w_rsp_valid_d;
    logic [1:0][7:0] w_rsp_rdata_d;

    // Reset is folded in so READY stays low while the block is held in reset.
    always_comb begin
        w_winner = io_bus.req_valid[1];
        if (&io_bus.req_valid) begin
            w_winner = r_pri;
        end
        w_accept = (r_state == StIdle) && i_rst_n && (|io_bus.req_valid);
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_pri   <= 1'b0;
            r_id    <= 1'b0;
            r_we    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            if (w_accept) begin
                r_pri <= ~w_winner;
                r_id  <= w_winner;
                r_we  <= io_bus.req_we[w_winner];
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_d = StStrobe;
                end
            end
            StStrobe: begin
                if (r_we) begin
                    w_state_d = StRecov;
                end else begin
                    w_state_d = StWait;
                    w_cnt_d   = LatCnt;
                end
            end
            StWait: begin
                w_cnt_d = r_cnt - 3'd1;
                if (r_cnt == 3'd1) begin
                    w_state_d = StIdle;
                end
            end
            StRecov: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Output logic: strobes are computed one cycle early and registered, so the
    // values loaded on the accept edge are what MEMCTRL sees throughout STROBE.
    always_comb begin
        w_ready       = '0;
        w_m_addr_d    = r_m_addr;
        w_m_ce_d      = 1'b0;
        w_m_csb_d     = 1'b1;
        w_m_web_d     = 1'b1;
        w_m_oeb_d     = 1'b1;
        w_m_idata_d   = 8'h00;
        w_rsp_valid_d = '0;
        w_rsp_rdata_d = r_rsp_rdata;

        if (w_accept) begin
            w_ready[w_winner] = 1'b1;
            w_m_addr_d        = io_bus.req_addr[w_winner];
            w_m_ce_d          = 1'b1;
            w_m_csb_d         = 1'b0;
            w_m_web_d         = ~io_bus.req_we[w_winner];
            w_m_oeb_d         = io_bus.req_we[w_winner];
            if (io_bus.req_we[w_winner]) begin
                w_m_idata_d = io_bus.req_wdata[w_winner];
            end
        end

        if ((r_state == StStrobe) && r_we) begin
            w_rsp_valid_d[r_id] = 1'b1;
        end

        if ((r_state == StWait) && (r_cnt == 3'd1)) begin
            w_rsp_valid_d[r_id] = 1'b1;
            w_rsp_rdata_d[r_id] = io_bus.m_odata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_m_addr    <= 16'h0000;
            r_m_ce      <= 1'b0;
            r_m_csb     <= 1'b1;
            r_m_web     <= 1'b1;
            r_m_oeb     <= 1'b1;
            r_m_idata   <= 8'h00;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
        end else begin
            r_m_addr    <= w_m_addr_d;
            r_m_ce      <= w_m_ce_d;
            r_m_csb     <= w_m_csb_d;
            r_m_web     <= w_m_web_d;
            r_m_oeb     <= w_m_oeb_d;
            r_m_idata   <= w_m_idata_d;
            r_rsp_valid <= w_rsp_valid_d;
            r_rsp_rdata <= w_rsp_rdata_d;
        end
    end

    assign io_bus.req_ready = w_ready;
    assign io_bus.rsp_valid = r_rsp_valid;
    assign io_bus.rsp_rdata = r_rsp_rdata;
    assign io_bus.m_addr    = r_m_addr;
    assign io_bus.m_ce      = r_m_ce;
    assign io_bus.m_csb     = r_m_csb;
    assign io_bus.m_web     = r_m_web;
    assign io_bus.m_oeb     = r_m_oeb;
    assign io_bus.m_idata   = r_m_idata;

    a_rd_lat_range: assert property (@(posedge i_clk) (RD_LAT >= 1) && (RD_LAT <= 4));

    a_ready_onehot: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        $onehot0(w_ready));

    a_ready_idle: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (|w_ready) |-> (r_state == StIdle));

    a_strobe_gap: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        r_m_ce |=> !r_m_ce);

    a_rsp_onehot: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        $onehot0(r_rsp_valid));

endmodule

// File: doc/memctrl_arbiter.md
# memctrl_arbiter

Two-port arbiter and access sequencer that sits in front of MEMCTRL and shares it between two requesters. It accepts byte read and write requests over a valid/ready handshake and picks a winner by round-robin. For each granted request it drives MEMCTRL's CE/CSB/WEB/OEB/ADDR/IDATA strobe sequence, then samples ODATA after a fixed read latency and returns a one-cycle response to the granted requester.

## Interface
- RD_LAT, 1 — cycles from the strobe cycle to the ODATA sample point; legal range 1..4.
- CLK  in  1  — single clock; all logic is rising-edge.
- RSTN  in  1  — asynchronous, active-low reset.
- REQ_VALID0 / REQ_VALID1  in  1  — request pending on requester 0 / 1.
- REQ_READY0 / REQ_READY1  out  1  — request accepted this cycle (a transfer occurs when VALID&READY).
- REQ_WE0 / REQ_WE1  in  1  — 1 means write, 0 means read.
- REQ_ADDR0 / REQ_ADDR1  in  16  — byte address.
- REQ_WDATA0 / REQ_WDATA1  in  8  — write data.
- RSP_VALID0 / RSP_VALID1  out  1  — one-cycle completion pulse.
- RSP_RDATA0 / RSP_RDATA1  out  8  — read data, valid with RSP_VALIDx. Holds its value otherwise.
- M_ADDR  out  16  — to MEMCTRL ADDR.
- M_CE  out  1  — to MEMCTRL CE (active high).
- M_CSB  out  1  — to MEMCTRL CSB (active low).
- M_WEB  out  1  — to MEMCTRL WEB (active low).
- M_OEB  out  1  — to MEMCTRL OEB (active low).
- M_IDATA  out  8  — to MEMCTRL IDATA.
- M_ODATA  in  8  — from MEMCTRL ODATA.

## Operation
- Reset values:
  - State = IDLE, PRI = 0.
  - M_ADDR = 0x0000, M_IDATA = 0x00.
  - M_CE = 0, M_CSB = 1, M_WEB = 1, M_OEB = 1.
  - RSP_VALIDx = 0, RSP_RDATAx = 0x00.
  - REQ_READYx = 0.
- All M_* outputs and RSP_* outputs are registered. REQ_READYx is combinational from state, PRI and VALIDs.
- States: IDLE, STROBE, WAIT, RECOV.
- IDLE:
  - Only one requester valid: that requester wins.
  - Both valid: requester PRI wins.
  - REQ_READY of the winner = 1. Its WE/ADDR/WDATA and ID are latched.
  - PRI <= ~winner.
  - Next state STROBE.
  - The memory outputs are loaded on this edge, so they are active throughout STROBE.
- STROBE (exactly 1 cycle):
  - M_CE = 1, M_CSB = 0, M_ADDR = latched address.
  - Write: M_WEB = 0, M_OEB = 1, M_IDATA = latched WDATA.
  - Read: M_WEB = 1, M_OEB = 0, M_IDATA = 0x00.
  - Next state: RECOV for a write, WAIT for a read (counter loaded with RD_LAT).
- WAIT (RD_LAT cycles):
  - Strobes idle: CE = 0, CSB = 1, WEB = 1, OEB = 1, IDATA = 0x00. M_ADDR holds.
  - M_ODATA is sampled at the end of the last WAIT cycle.
  - RSP_VALID[id] = 1 and RSP_RDATA[id] = sampled value in the following cycle.
  - Next state IDLE.
- RECOV (1 cycle, writes only):
  - Strobes idle.
  - RSP_VALID[id] = 1 this cycle. RSP_RDATA is unchanged.
  - Next state IDLE.
- Response pulses last exactly one cycle. A response may coincide with a new acceptance in IDLE.
- Requesters hold WE/ADDR/WDATA stable while VALID=1 and READY=0. The block does not check this.
- A requester may drop VALID before acceptance; it is then simply not arbitrated.
- Asynchronous reset mid-access:
  - Immediate return to reset values; strobes deassert asynchronously.
  - The in-flight request is dropped and no response is issued.
  - PRI returns to 0.

## Timing
- Write: accept at cycle T, strobe at T+1, RSP_VALID at T+2, next accept possible at T+3. Throughput is 3 cycles per write.
- Read: accept at T, strobe at T+1, WAIT at T+2..T+1+RD_LAT, RSP_VALID at T+2+RD_LAT (= IDLE, where a new accept may occur). Throughput is 2+RD_LAT cycles per read.
- Any strobe cycle is followed by at least 1 idle cycle (CE = 0, CSB = 1).
- REQ_READYx is never 1 outside IDLE. At most one READY is high in any cycle.
- No accept takes place in the cycle RSTN deasserts if the deassertion is within setup of the edge. Otherwise the first accept may occur on the first edge with RSTN = 1.

## Test plan
- Write, RD_LAT = 1: R0 writes 0xA5 to address 0x0010, accepted at T.
  - T+1: M_CE = 1, M_CSB = 0, M_WEB = 0, M_OEB = 1, M_ADDR = 0x0010, M_IDATA = 0xA5.
  - T+2: strobes idle, RSP_VALID0 = 1.
- Read, RD_LAT = 1: R1 reads 0x0010 (memory model returns 0xA5), accepted at T.
  - T+1: M_OEB = 0, M_WEB = 1.
  - T+3: RSP_VALID1 = 1, RSP_RDATA1 = 0xA5. RSP_VALID0 stays 0.
- Contention: both VALIDs held high from reset with writes.
  - Grants alternate R0, R1, R0, R1, starting with R0.
  - Accept cycles spaced exactly 3 apart; no overlapping strobes.
- Burst: 10 sequential writes from R0 to 0x0000..0x0009 with random data, then 10 reads from R1.
  - Every read returns the written byte.
  - Every strobe cycle is followed by at least 1 idle cycle.
- RD_LAT = 3 read: RSP_VALID at T+5. M_ODATA is sampled at the end of T+4; a change at T+5 must not appear in RSP_RDATA.
- Reset mid-read: RSTN pulled low during WAIT.
  - All outputs take reset values immediately.
  - No RSP_VALID appears after RSTN deasserts.
  - The next contended grant goes to R0.
